// File: rtl/histogram_frame_sequencer.sv
// Per-frame controller for a 256-bin grey-level histogram RAM.
// Each frame runs: clear every bin, gate one frame of pixels into the
// histogram, wait for the histogram read-modify-write pipe to drain, then
// scan the bins to build a cumulative distribution and write an 8-bit
// equalisation LUT for the downstream remap stage.
//
// Strobe semantics: oHistValid, oHistClear and oLutWe are single-cycle
// qualifiers with no back-pressure. The consumer must take the beat
// (pixel, clear address or LUT entry) on every cycle the strobe is high.
// oLutReady is a one-cycle pulse once the last LUT entry has been written.
module histogram_frame_sequencer #(
  parameter int PIX_LOG2  = 19,
  parameter int DRAIN_CYC = 2
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iStart,
  input  logic        iFrameStart,
  input  logic        iFrameEnd,
  input  logic        iPixValid,
  output logic        oHistValid,
  output logic        oHistClear,
  output logic [7:0]  oClrAddr,
  output logic [7:0]  oScanAddr,
  input  logic [19:0] iScanData,
  output logic        oLutWe,
  output logic [7:0]  oLutAddr,
  output logic [7:0]  oLutData,
  output logic [19:0] oPixCount,
  output logic        oBusy,
  output logic        oLutReady,
  output logic        oOverrun,
  output logic [2:0]  oDbgState
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_CLEAR      = 3'd1,
    S_WAIT_FRAME = 3'd2,
    S_ACCUM      = 3'd3,
    S_DRAIN      = 3'd4,
    S_SCAN       = 3'd5,
    S_DONE       = 3'd6
  } state_e;

  // Last count value of the drain window (DRAIN_CYC must be at least 1).
  localparam logic [8:0] DRAIN_LAST = 9'(DRAIN_CYC - 1);
  localparam logic [19:0] PIX_MAX   = 20'hFFFFF;

  state_e      state_q, state_d;
  // Shared phase counter: clear address, drain count, scan index (0..256).
  logic [8:0]  cnt_q, cnt_d;
  logic [19:0] cdf_q, cdf_d;
  logic [19:0] pix_q, pix_d;
  logic        overrun_q, overrun_d;

  logic        hist_valid_c;
  logic        hist_clear_c;
  logic        lut_we_c;
  logic        lut_ready_c;
  logic [7:0]  scan_addr_c;
  logic [7:0]  lut_addr_c;

  // Scan datapath: saturating cdf update and normalised LUT value.
  logic [20:0] cdf_sum;
  logic [19:0] cdf_new;
  logic [27:0] lut_prod;
  logic [27:0] lut_shift;
  logic [7:0]  lut_val;

  assign cdf_sum   = {1'b0, cdf_q} + {1'b0, iScanData};
  assign cdf_new   = cdf_sum[20] ? PIX_MAX : cdf_sum[19:0];
  assign lut_prod  = {8'd0, cdf_new} * 28'd255;
  assign lut_shift = lut_prod >> PIX_LOG2;
  assign lut_val   = (lut_shift > 28'd255) ? 8'hFF : lut_shift[7:0];

  // State, counters, cdf accumulator and sticky overrun flag.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 9'd0;
      cdf_q     <= 20'd0;
      pix_q     <= 20'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cdf_q     <= cdf_d;
      pix_q     <= pix_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cdf_d        = cdf_q;
    pix_d        = pix_q;
    overrun_d    = overrun_q;
    hist_valid_c = 1'b0;
    hist_clear_c = 1'b0;
    lut_we_c     = 1'b0;
    lut_ready_c  = 1'b0;
    scan_addr_c  = 8'd0;
    lut_addr_c   = 8'd0;

    // A frame start is only legal while waiting for one; anywhere else in
    // the busy sequence it means upstream and this block are out of step.
    if (iFrameStart && (state_q != S_IDLE) && (state_q != S_WAIT_FRAME)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_CLEAR;
          cnt_d   = 9'd0;
        end
      end

      S_CLEAR: begin
        hist_clear_c = 1'b1;
        if (cnt_q[7:0] == 8'd255) begin
          state_d = S_WAIT_FRAME;
          cnt_d   = 9'd0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      S_WAIT_FRAME: begin
        if (iFrameStart) begin
          state_d = S_ACCUM;
          pix_d   = iPixValid ? 20'd1 : 20'd0;
        end
      end

      S_ACCUM: begin
        hist_valid_c = iPixValid;
        if (iPixValid && (pix_q != PIX_MAX)) begin
          pix_d = pix_q + 20'd1;
        end
        if (iFrameEnd) begin
          state_d = S_DRAIN;
          cnt_d   = 9'd0;
        end
      end

      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_SCAN;
          cnt_d   = 9'd0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      S_SCAN: begin
        // Index 256 is the tail cycle that consumes the data for bin 255.
        scan_addr_c = cnt_q[8] ? 8'hFF : cnt_q[7:0];
        if (cnt_q != 9'd0) begin
          cdf_d      = cdf_new;
          lut_we_c   = 1'b1;
          lut_addr_c = cnt_q[7:0] - 8'd1;
        end
        if (cnt_q == 9'd256) begin
          state_d = S_DONE;
          cnt_d   = 9'd0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      S_DONE: begin
        lut_ready_c = 1'b1;
        cdf_d       = 20'd0;
        state_d     = S_CLEAR;
        cnt_d       = 9'd0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = 9'd0;
      end
    endcase
  end

  assign oHistValid = hist_valid_c;
  assign oHistClear = hist_clear_c;
  assign oClrAddr   = hist_clear_c ? cnt_q[7:0] : 8'd0;
  assign oScanAddr  = scan_addr_c;
  assign oLutWe     = lut_we_c;
  assign oLutAddr   = lut_addr_c;
  assign oLutData   = lut_we_c ? lut_val : 8'd0;
  assign oPixCount  = pix_q;
  assign oBusy      = (state_q != S_IDLE);
  assign oLutReady  = lut_ready_c;
  assign oOverrun   = overrun_q;
  assign oDbgState  = state_q;

endmodule
